acquisition_scheduler: RTL and testbench
========================================

# acquisition_scheduler

Sequences sensor sampling for the predictive-maintenance datapath. A programmable sample-period timer triggers a frame. For each frame, the block requests one conversion per enabled channel from the data acquisition front end, in ascending channel order. Each returned sample goes out on a valid/ready stream tagged with its channel and an end-of-frame marker. The block sits between the `data_acquisition` front end and the downstream feature-extraction/FIFO stage.

## Interface
- `NUM_CH`, 4: number of sensor channels (1–16).
- `DATA_W`, 16: sample width; matches `sensor_data`.
- `DIV_W`, 16: width of the sample-period register.
- `TIMEOUT`, 64: max cycles to wait for an acquisition acknowledge (≥2).

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `enable`  in  1  1 = period timer runs; 0 = timer held at 0, no new frames.
- `sample_period`  in  `DIV_W`  frame period in cycles; 0 is treated as 1.
- `ch_mask`  in  `NUM_CH`  enabled channels; latched at each accepted tick.
- `clear_flags`  in  1  one-cycle pulse; clears the `overrun` and `timeout_err` flags.
- `acq_req`  out  1  conversion request to the front end.
- `acq_ch`  out  `clog2(NUM_CH)` (min 1)  channel being requested.
- `acq_valid`  in  1  front-end acknowledge; `acq_data` is valid in the same cycle.
- `acq_data`  in  `DATA_W`  converted sample.
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream ready.
- `out_data`  out  `DATA_W`  sample.
- `out_ch`  out  `clog2(NUM_CH)`  channel tag.
- `out_last`  out  1  last sample of the frame.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `overrun`  out  1  sticky: a tick arrived while a frame was in progress.
- `timeout_err`  out  1  sticky: at least one request timed out.
- `frame_cnt`  out  16  completed frames; wraps 0xFFFF→0.

## Operation

**Timer**
- Counter `cnt` increments while `enable=1`.
- `tick` is asserted when `cnt == max(sample_period,1)-1`; `cnt` then returns to 0.
- `enable=0` forces `cnt=0` and `tick=0`.

**States**
- **IDLE**
  - On `tick` with latched mask ≠ 0: latch `ch_mask` into `pend` and go to REQ, with `ch` = lowest set bit.
  - On `tick` with mask = 0: stay in IDLE. No frame starts, `frame_cnt` is unchanged, and no flag is set.
- **REQ**
  - `acq_req=1`, `acq_ch=ch`, timeout counter `tcnt` increments.
  - On `acq_valid`: capture `acq_data`, clear bit `ch` of `pend`, go to PUSH.
  - If `tcnt` reaches `TIMEOUT` without `acq_valid`: set `timeout_err`, clear bit `ch`, produce no output for that channel.
    - Go to REQ for the next pending channel, or to IDLE if none remain.
    - The frame still counts as completed.
- **PUSH**
  - `out_valid=1` with `out_data`, `out_ch` and `out_last` held stable until `out_valid & out_ready`.
  - `out_last=1` iff `pend` is empty after this channel.
  - On handshake: go to REQ for the lowest remaining `pend` bit, or to IDLE with `frame_cnt += 1`.

**Boundary behaviour**
- **Tick while busy:** set `overrun`; the tick is dropped and not queued. The current frame continues unchanged.
- **`ch_mask` changes mid-frame:** ignored until the next accepted tick.
- **`enable` deasserted mid-frame:** the current frame completes, and no further ticks occur.
- **Timeout on the last channel:** the frame ends with no `out_last` beat. Downstream relies on `frame_cnt`.
- **`clear_flags` in the same cycle as a flag-setting event:** the set wins.
- **`acq_valid` outside REQ:** ignored.
- **Reset asserted at any time:** all state returns to reset values immediately, and any frame in progress is abandoned.

## Timing
- **Reset values:** state IDLE; `cnt=0`; `acq_req=0`; `acq_ch=0`; `out_valid=0`; `out_data=0`; `out_ch=0`; `out_last=0`; `busy=0`; `overrun=0`; `timeout_err=0`; `frame_cnt=0`.
- **Tick at edge t:** `acq_req=1` in cycle t+1.
- **`acq_valid` sampled high at edge u:** `acq_req=0` and `out_valid=1` in cycle u+1.
- **Handshake at edge v:** `acq_req=1` for the next channel in cycle v+1.
- **Per-sample overhead:** minimum 2 cycles (REQ→PUSH) when the acknowledge and ready are immediate.
- **Timeout boundary:** `tcnt` resets on entry to REQ. The timeout fires on the `TIMEOUT`-th REQ cycle with no acknowledge; an acknowledge in that same cycle wins.
- **Timer during a frame:** keeps counting, so the period is independent of frame duration.
- **All outputs are registered.**

## Test plan
- **Basic frame:** `sample_period=10`, `ch_mask=4'b0101`, front end acks 2 cycles after `acq_req`, `out_ready=1`.
  - Expect out beats ch0 then ch2, with `out_last` only on ch2.
  - Expect `frame_cnt`=1, then 2 after the next tick, 10 cycles later.
- **Backpressure:** same setup with `out_ready=0` for 5 cycles on the ch0 beat.
  - Expect `out_data`/`out_ch` stable while waiting.
  - Expect `acq_req` for ch2 only after the handshake.
- **Timeout:** `TIMEOUT=64`, `ch_mask=4'b0011`, ch0 never acks.
  - Expect `acq_req` high for exactly 64 cycles, then `timeout_err=1`.
  - Expect ch1 sampled normally with `out_last=1`; `clear_flags` then returns `timeout_err` to 0.
- **Overrun:** `sample_period=3`, `ch_mask=4'b1111`, ack latency 4.
  - Expect `overrun=1` after the first busy tick; no extra frames are queued.
  - Expect the frames to contain ch0..ch3 in order.
- **Mask zero / period zero:** `ch_mask=0`, then `sample_period=0` with `ch_mask=4'b0001` and immediate ack/ready.
  - Expect no activity while mask=0.
  - With period 0, expect a tick every cycle and `overrun` set.
- **Reset mid-frame:** assert `reset=0` while `out_valid=1`.
  - Expect all outputs at reset values in the same cycle.
  - After release, the first frame starts at channel 0 with `frame_cnt=0`.

Source files
------------

// File: rtl/acquisition_scheduler.sv
// Frame scheduler: a period timer starts a frame that requests one conversion per enabled
// channel (ascending order) and streams each returned sample out, tagged with channel and last.
module acquisition_scheduler #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 16,
   parameter int DIV_W   = 16,
   parameter int TIMEOUT = 64,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DIV_W-1:0]  sample_period,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              clear_flags,
   output logic              acq_req,
   output logic [CH_W-1:0]   acq_ch,
   input  logic              acq_valid,
   input  logic [DATA_W-1:0] acq_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CH_W-1:0]   out_ch,
   output logic              out_last,
   output logic              busy,
   output logic              overrun,
   output logic              timeout_err,
   output logic [15:0]       frame_cnt,
   output logic [1:0]        state_dbg
);

   // Handshakes: an output beat transfers on a rising edge where out_valid & out_ready, and
   // out_data/out_ch/out_last hold until then; acq_valid is a one-cycle acknowledge that is
   // only looked at while acq_req is high (REQ state).

   localparam int TCNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_PUSH = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    cnt_q, cnt_d;
   logic [DIV_W-1:0]    period_m1;
   logic                tick;
   logic [NUM_CH-1:0]   pend_q, pend_d;
   logic [NUM_CH-1:0]   pend_clr;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CH_W-1:0]     out_ch_q, out_ch_d;
   logic                out_last_q, out_last_d;
   logic                out_valid_q;
   logic                acq_req_q;
   logic                busy_q;
   logic                overrun_q, overrun_d;
   logic                timeout_q, timeout_d;
   logic                set_overrun, set_timeout;
   logic [15:0]         frame_cnt_q, frame_cnt_d;

   function automatic logic [CH_W-1:0] lowest_bit(input logic [NUM_CH-1:0] m);
      lowest_bit = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) lowest_bit = CH_W'(i);
      end
   endfunction

   // Compare with >= so that shrinking sample_period below the running count still ticks.
   always_comb begin
      period_m1 = (sample_period == '0) ? '0 : sample_period - DIV_W'(1);
      tick      = enable && (cnt_q >= period_m1);
      cnt_d     = (!enable || tick) ? '0 : cnt_q + DIV_W'(1);
   end

   assign pend_clr = pend_q & ~(NUM_CH'(1) << ch_q);

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      ch_d        = ch_q;
      tcnt_d      = tcnt_q;
      data_d      = data_q;
      out_ch_d    = out_ch_q;
      out_last_d  = out_last_q;
      frame_cnt_d = frame_cnt_q;
      set_timeout = 1'b0;
      set_overrun = tick && (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (tick && (ch_mask != '0)) begin
               pend_d  = ch_mask;
               ch_d    = lowest_bit(ch_mask);
               tcnt_d  = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (acq_valid) begin
               data_d     = acq_data;
               pend_d     = pend_clr;
               out_ch_d   = ch_q;
               out_last_d = (pend_clr == '0);
               state_d    = S_PUSH;
            end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
               // Skip the silent channel; a frame ending this way still counts as done.
               set_timeout = 1'b1;
               pend_d      = pend_clr;
               tcnt_d      = '0;
               if (pend_clr != '0) begin
                  ch_d    = lowest_bit(pend_clr);
                  state_d = S_REQ;
               end else begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  state_d     = S_IDLE;
               end
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         S_PUSH: begin
            if (out_ready) begin
               if (pend_q != '0) begin
                  ch_d    = lowest_bit(pend_q);
                  tcnt_d  = '0;
                  state_d = S_REQ;
               end else begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  state_d     = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      overrun_d = set_overrun || (overrun_q && !clear_flags);
      timeout_d = set_timeout || (timeout_q && !clear_flags);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pend_q      <= '0;
         ch_q        <= '0;
         tcnt_q      <= '0;
         data_q      <= '0;
         out_ch_q    <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         acq_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         ch_q        <= ch_d;
         tcnt_q      <= tcnt_d;
         data_q      <= data_d;
         out_ch_q    <= out_ch_d;
         out_last_q  <= out_last_d;
         out_valid_q <= (state_d == S_PUSH);
         acq_req_q   <= (state_d == S_REQ);
         busy_q      <= (state_d != S_IDLE);
         overrun_q   <= overrun_d;
         timeout_q   <= timeout_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign acq_req     = acq_req_q;
   assign acq_ch      = ch_q;
   assign out_valid   = out_valid_q;
   assign out_data    = data_q;
   assign out_ch      = out_ch_q;
   assign out_last    = out_last_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;
   assign timeout_err = timeout_q;
   assign frame_cnt   = frame_cnt_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_acquisition_scheduler.sv
// Bench for acquisition_scheduler: a front-end/sink model on the falling edge, a table of
// single-frame vectors, and hand-written sequences for timing, backpressure, timeout, overrun, reset.
module tb_acquisition_scheduler;
   localparam int NUM_CH = 4;
   localparam int DATA_W = 16;
   localparam int CH_W   = 2;
   localparam int BEAT_W = DATA_W + CH_W + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic [15:0]       sample_period;
   logic [NUM_CH-1:0] ch_mask;
   logic              clear_flags;
   logic              acq_req;
   logic [CH_W-1:0]   acq_ch;
   logic              acq_valid;
   logic [DATA_W-1:0] acq_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CH_W-1:0]   out_ch;
   logic              out_last;
   logic              busy;
   logic              overrun;
   logic              timeout_err;
   logic [15:0]       frame_cnt;
   logic [1:0]        state_dbg;

   acquisition_scheduler #(.NUM_CH(4), .DATA_W(16), .DIV_W(16), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .enable(enable), .sample_period(sample_period),
      .ch_mask(ch_mask), .clear_flags(clear_flags), .acq_req(acq_req), .acq_ch(acq_ch),
      .acq_valid(acq_valid), .acq_data(acq_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ch(out_ch), .out_last(out_last), .busy(busy),
      .overrun(overrun), .timeout_err(timeout_err), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int               checks = 0;
   int               errors = 0;
   int               cycle  = 0;
   logic [BEAT_W-1:0] exp_q[$];
   logic [15:0]      exp_frames;
   int               ack_lat;
   logic [3:0]       dead_mask;
   int               stall_left;
   logic [7:0]       tag;
   int               age;
   logic             req_prev;
   logic [CH_W-1:0]  ch_prev;

   typedef struct {
      int         period;
      logic [3:0] mask;
      int         lat;
      logic [3:0] dead;
      int         n_beats;
      logic [7:0] chs;
      logic       last;
   } vec_t;
   vec_t tbl[7];

   always @(posedge clk) cycle++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic logic [DATA_W-1:0] fe_data(input logic [CH_W-1:0] c);
      return {8'hD0 | 8'(c), tag};
   endfunction

   // Front end acks ack_lat cycles after a request appears; the sink stalls stall_left cycles.
   always @(negedge clk) begin
      if (!reset) begin
         acq_valid = 1'b0;
         acq_data  = '0;
         age       = 0;
         req_prev  = 1'b0;
         out_ready = 1'b1;
      end else begin
         if (acq_req && req_prev && (acq_ch == ch_prev)) age++;
         else age = acq_req ? 1 : 0;
         req_prev  = acq_req;
         ch_prev   = acq_ch;
         acq_valid = acq_req && (age > ack_lat) && !dead_mask[acq_ch];
         acq_data  = acq_valid ? fe_data(acq_ch) : '0;
         if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat: unexpected beat ch=%0d data=%0h last=%0b", out_ch, out_data, out_last);
            end else begin
               logic [BEAT_W-1:0] e;
               e = exp_q.pop_front();
               if ({out_last, out_ch, out_data} !== e) begin
                  errors++;
                  $display("FAIL beat: got last=%0b ch=%0d data=%0h expected last=%0b ch=%0d data=%0h",
                           out_last, out_ch, out_data, e[BEAT_W-1], e[DATA_W +: CH_W], e[DATA_W-1:0]);
               end
            end
         end
      end
   end

   task automatic push_beat(input logic [CH_W-1:0] c, input logic last);
      exp_q.push_back({last, c, fe_data(c)});
   endtask

   task automatic pulse_clear();
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
   endtask

   task automatic wait_frames(input int budget);
      int n = 0;
      while (frame_cnt !== exp_frames && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("frame_wait", frame_cnt, exp_frames);
   endtask

   task automatic wait_sig(input string name, input int which, input int budget);
      int n = 0;
      while (!((which == 0) ? acq_req : out_valid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, (which == 0) ? acq_req : out_valid, 1);
   endtask

   task automatic check_reset_outputs(input string p);
      check({p, "_acq_req"}, acq_req, 0);
      check({p, "_acq_ch"}, acq_ch, 0);
      check({p, "_out_valid"}, out_valid, 0);
      check({p, "_out_data"}, out_data, 0);
      check({p, "_out_ch"}, out_ch, 0);
      check({p, "_out_last"}, out_last, 0);
      check({p, "_busy"}, busy, 0);
      check({p, "_overrun"}, overrun, 0);
      check({p, "_timeout_err"}, timeout_err, 0);
      check({p, "_frame_cnt"}, frame_cnt, 0);
      check({p, "_state"}, state_dbg, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int t1;
      tbl[0] = '{10,  4'b0101, 2, 4'b0000, 2, 8'h08, 1'b1};
      tbl[1] = '{20,  4'b1111, 0, 4'b0000, 4, 8'hE4, 1'b1};
      tbl[2] = '{7,   4'b1000, 1, 4'b0000, 1, 8'h03, 1'b1};
      tbl[3] = '{30,  4'b0110, 5, 4'b0000, 2, 8'h09, 1'b1};
      tbl[4] = '{200, 4'b0011, 1, 4'b0001, 1, 8'h01, 1'b1};
      tbl[5] = '{200, 4'b0100, 0, 4'b0100, 0, 8'h00, 1'b0};
      tbl[6] = '{200, 4'b1010, 0, 4'b1000, 1, 8'h01, 1'b0};

      reset = 1'b0; enable = 1'b0; sample_period = 16'd10; ch_mask = '0; clear_flags = 1'b0;
      ack_lat = 0; dead_mask = '0; stall_left = 0; tag = 8'h00; exp_frames = '0;
      acq_valid = 1'b0; acq_data = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b1;
      @(negedge clk);

      // Basic frame: tick-to-request latency and frame period
      sample_period = 16'd10; ch_mask = 4'b0101; ack_lat = 2; tag = 8'h01;
      repeat (2) begin
         push_beat(2'd0, 1'b0);
         push_beat(2'd2, 1'b1);
      end
      enable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!acq_req && n < 40);
      check("tick_to_req", n, 10);
      check("first_ch", acq_ch, 0);
      exp_frames++;
      wait_frames(100);
      t1 = cycle;
      exp_frames++;
      wait_frames(100);
      check("frame_period", cycle - t1, 10);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("basic_q_empty", exp_q.size(), 0);

      // Table of single frames
      for (int k = 0; k < 7; k++) begin
         enable = 1'b0;
         sample_period = 16'(tbl[k].period);
         ch_mask = tbl[k].mask;
         ack_lat = tbl[k].lat;
         dead_mask = tbl[k].dead;
         tag = 8'h10 + 8'(k);
         pulse_clear();
         for (int b = 0; b < tbl[k].n_beats; b++)
            push_beat(tbl[k].chs[2*b +: 2], (b == tbl[k].n_beats - 1) ? tbl[k].last : 1'b0);
         exp_frames++;
         enable = 1'b1;
         wait_frames(400);
         enable = 1'b0;
         repeat (3) @(negedge clk);
         check($sformatf("vec%0d_q_empty", k), exp_q.size(), 0);
         check($sformatf("vec%0d_busy", k), busy, 0);
         check($sformatf("vec%0d_overrun", k), overrun, 0);
         check($sformatf("vec%0d_timeout_err", k), timeout_err, (tbl[k].dead != 0) ? 1 : 0);
      end
      dead_mask = '0;

      // Backpressure on the ch0 beat; enable dropped mid-frame
      sample_period = 16'd10; ch_mask = 4'b0101; ack_lat = 2; tag = 8'h20;
      pulse_clear();
      stall_left = 5;
      push_beat(2'd0, 1'b0);
      push_beat(2'd2, 1'b1);
      exp_frames++;
      enable = 1'b1;
      wait_sig("bp_valid", 1, 60);
      enable = 1'b0;
      for (int s = 0; s < 6; s++) begin
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_ch", out_ch, 0);
         check("bp_hold_data", out_data, 16'hD020);
         check("bp_no_req", acq_req, 0);
         @(negedge clk);
      end
      check("bp_next_req", acq_req, 1);
      check("bp_next_ch", acq_ch, 2);
      check("bp_valid_drop", out_valid, 0);
      wait_frames(60);
      repeat (3) @(negedge clk);
      check("bp_q_empty", exp_q.size(), 0);
      check("bp_overrun", overrun, 0);

      // Timeout: ch0 silent for exactly 64 request cycles
      sample_period = 16'd100; ch_mask = 4'b0011; ack_lat = 0; dead_mask = 4'b0001; tag = 8'h30;
      pulse_clear();
      push_beat(2'd1, 1'b1);
      exp_frames++;
      enable = 1'b1;
      wait_sig("to_req", 0, 200);
      enable = 1'b0;
      n = 0;
      while (acq_req && acq_ch == 2'd0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("to_req_cycles", n, 64);
      check("to_flag", timeout_err, 1);
      check("to_next_req", acq_req, 1);
      wait_frames(40);
      pulse_clear();
      check("to_cleared", timeout_err, 0);
      dead_mask = '0;

      // Overrun: period 3 with 24-cycle frames
      sample_period = 16'd3; ch_mask = 4'b1111; ack_lat = 4; tag = 8'h40;
      pulse_clear();
      repeat (2)
         for (int c = 0; c < 4; c++) push_beat(2'(c), c == 3);
      exp_frames++;
      enable = 1'b1;
      wait_frames(200);
      check("ovr_set", overrun, 1);
      exp_frames++;
      wait_frames(200);
      enable = 1'b0;
      repeat (10) @(negedge clk);
      check("ovr_frames", frame_cnt, exp_frames);
      check("ovr_q_empty", exp_q.size(), 0);
      check("ovr_busy", busy, 0);
      check("ovr_sticky", overrun, 1);

      // Mask zero: no activity
      sample_period = 16'd4; ch_mask = 4'b0000;
      pulse_clear();
      enable = 1'b1;
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy || acq_req || out_valid) n++;
      end
      enable = 1'b0;
      check("mask0_activity", n, 0);
      check("mask0_frames", frame_cnt, exp_frames);
      check("mask0_overrun", overrun, 0);

      // Period zero: tick every cycle, frames back to back, overrun set
      sample_period = 16'd0; ch_mask = 4'b0001; ack_lat = 0; tag = 8'h50;
      repeat (3) push_beat(2'd0, 1'b1);
      exp_frames += 16'd3;
      enable = 1'b1;
      wait_frames(60);
      enable = 1'b0;
      repeat (5) @(negedge clk);
      check("p0_frames", frame_cnt, exp_frames);
      check("p0_q_empty", exp_q.size(), 0);
      check("p0_overrun", overrun, 1);

      // Reset while a beat is stalled
      sample_period = 16'd10; ch_mask = 4'b0101; ack_lat = 2; tag = 8'h60;
      pulse_clear();
      stall_left = 20;
      enable = 1'b1;
      wait_sig("mid_valid", 1, 60);
      reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      enable = 1'b0;
      stall_left = 0;
      exp_q.delete();
      exp_frames = '0;
      @(negedge clk);
      reset = 1'b1;
      tag = 8'h61;
      push_beat(2'd0, 1'b0);
      push_beat(2'd2, 1'b1);
      exp_frames = 16'd1;
      enable = 1'b1;
      wait_sig("post_req", 0, 60);
      check("post_ch", acq_ch, 0);
      check("post_frame_cnt", frame_cnt, 0);
      wait_frames(60);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("post_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
